// File: rtl/xpar_bridge_pkg.sv
// Shared definitions for the external parallel-port bridge.
//
// Contents:
//   - default channel count, wait-state and timeout values
//   - FSM state encoding shared by the bridge and anything that observes its state
//   - clog2_min1(): channel-index width helper that never returns 0
package xpar_bridge_pkg;

  localparam int unsigned XparNChDefault     = 4;
  localparam int unsigned XparWaitDefault    = 1;
  localparam int unsigned XparTimeoutDefault = 64;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } xpar_state_e;

  // A single channel still needs a 1-bit index field in the address.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xpar_rdmux.sv
// N:1 read-data multiplexer for parallel channels.
//
// Selects the DATA_W-bit slice of a packed channel bus by index. Channel k occupies
// bits [k*DATA_W +: DATA_W]. An index beyond the last channel returns zero.
//
// Ports:
//   data_i  packed read data from all channels
//   sel_i   channel index
//   data_o  selected channel's read data
module xpar_rdmux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic [N_CH*DATA_W-1:0] data_i,
  input  logic [SEL_W-1:0]       sel_i,
  output logic [DATA_W-1:0]      data_o
);

  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/xpar_bridge.sv
// Controller-bus to N_CH external parallel channel bridge.
//
// Each access is latched in IDLE, strobed onto exactly one channel for at least
// WAIT_CYC cycles (and, with USE_ACK, until that channel acks), then retired in a
// one-cycle DONE. The controller is stalled from the cycle it presents sel until
// the access leaves ACCESS. An access still pending after TIMEOUT strobe cycles is
// aborted, recorded in sticky err/err_ch, and reads return all ones.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   sel, we    bridge select, write (1) / read (0)
//   addr       {channel, local address}
//   data_in    write data
//   data_out   read data, held until the next read completes
//   stall      controller must hold the bus while high
//   err        sticky timeout flag; err_ch = channel of the last timeout
//   ch_sel     one-hot channel strobe
//   ch_addr    local address to channels
//   ch_out     write data to channels
//   ch_re      read strobe; ch_we write strobe
//   ch_in      packed read data from channels
//   ch_ack     per-channel ready
module xpar_bridge
  import xpar_bridge_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned N_CH     = XparNChDefault,
  parameter int unsigned CH_W     = clog2_min1(N_CH),
  parameter int unsigned WAIT_CYC = XparWaitDefault,
  parameter bit          USE_ACK  = 1'b1,
  parameter int unsigned TIMEOUT  = XparTimeoutDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel,
  input  logic                   we,
  input  logic [ADDR_W-2:0]      addr,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   stall,
  output logic                   err,
  output logic [CH_W-1:0]        err_ch,
  output logic [N_CH-1:0]        ch_sel,
  output logic [ADDR_W-2-CH_W:0] ch_addr,
  output logic [DATA_W-1:0]      ch_out,
  output logic                   ch_re,
  output logic                   ch_we,
  input  logic [N_CH*DATA_W-1:0] ch_in,
  input  logic [N_CH-1:0]        ch_ack
);

  localparam int unsigned LaW  = ADDR_W - 1 - CH_W;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] WaitCnt    = CntW'(WAIT_CYC);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  xpar_state_e state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Latched transaction
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              we_q, we_d;
  logic [LaW-1:0]    laddr_q, laddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Registered outputs
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              err_q, err_d;
  logic [CH_W-1:0]   err_ch_q, err_ch_d;
  logic [N_CH-1:0]   ch_sel_q, ch_sel_d;
  logic [LaW-1:0]    ch_addr_q, ch_addr_d;
  logic [DATA_W-1:0] ch_out_q, ch_out_d;
  logic              ch_re_q, ch_re_d;
  logic              ch_we_q, ch_we_d;

  logic [DATA_W-1:0] rd_data;
  logic              ack_sel;
  logic              complete;
  logic              timed_out;
  logic              access_d;

  xpar_rdmux #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH),
    .SEL_W  (CH_W)
  ) u_rdmux (
    .data_i (ch_in),
    .sel_i  (ch_q),
    .data_o (rd_data)
  );

  // Only the addressed channel's ack counts; acks on other channels are ignored.
  always_comb begin
    ack_sel = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        ack_sel = ch_ack[k];
      end
    end
  end

  assign complete  = (cnt_q >= WaitCnt) && (!USE_ACK || ack_sel);
  // Completion takes priority when both happen on the final strobe cycle.
  assign timed_out = (cnt_q == TimeoutCnt) && !complete;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    we_d       = we_q;
    laddr_d    = laddr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    err_d      = err_q;
    err_ch_d   = err_ch_q;

    unique case (state_q)
      StIdle: begin
        if (sel) begin
          state_d = StAccess;
          cnt_d   = CntW'(1);
          ch_d    = addr[ADDR_W-2 -: CH_W];
          laddr_d = addr[LaW-1:0];
          we_d    = we;
          wdata_d = data_in;
        end
      end
      StAccess: begin
        if (complete) begin
          if (!we_q) begin
            data_out_d = rd_data;
          end
          state_d = StDone;
        end else if (timed_out) begin
          err_d    = 1'b1;
          err_ch_d = ch_q;
          if (!we_q) begin
            data_out_d = '1;
          end
          state_d = StDone;
        end else if (cnt_q != TimeoutCnt) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes are registered from next-state so they are high exactly while in ACCESS.
  always_comb begin
    access_d  = (state_d == StAccess);
    ch_sel_d  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      ch_sel_d[k] = access_d && (ch_d == CH_W'(k));
    end
    ch_re_d   = access_d && !we_d;
    ch_we_d   = access_d && we_d;
    ch_addr_d = access_d ? laddr_d : '0;
    ch_out_d  = access_d ? wdata_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ch_q       <= '0;
      we_q       <= 1'b0;
      laddr_q    <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
      err_ch_q   <= '0;
      ch_sel_q   <= '0;
      ch_addr_q  <= '0;
      ch_out_q   <= '0;
      ch_re_q    <= 1'b0;
      ch_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      we_q       <= we_d;
      laddr_q    <= laddr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
      err_ch_q   <= err_ch_d;
      ch_sel_q   <= ch_sel_d;
      ch_addr_q  <= ch_addr_d;
      ch_out_q   <= ch_out_d;
      ch_re_q    <= ch_re_d;
      ch_we_q    <= ch_we_d;
    end
  end

  // The controller must see stall in the same cycle it raises sel.
  assign stall    = ((state_q == StIdle) && sel) || (state_q == StAccess);
  assign data_out = data_out_q;
  assign err      = err_q;
  assign err_ch   = err_ch_q;
  assign ch_sel   = ch_sel_q;
  assign ch_addr  = ch_addr_q;
  assign ch_out   = ch_out_q;
  assign ch_re    = ch_re_q;
  assign ch_we    = ch_we_q;

endmodule

// File: tb/tb_xpar_bridge.sv
module tb_xpar_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         we;
  logic [10:0]  addr;
  logic [31:0]  data_in;
  logic [127:0] ch_in;

  // dut_a: WAIT_CYC=1, USE_ACK=0. dut_b: WAIT_CYC=3, USE_ACK=1, TIMEOUT=64.
  logic        sel_a, sel_b;
  logic [3:0]  ack_a, ack_b;
  logic [31:0] data_out_a, data_out_b, ch_out_a, ch_out_b;
  logic        stall_a, stall_b, err_a, err_b;
  logic [1:0]  err_ch_a, err_ch_b;
  logic [3:0]  ch_sel_a, ch_sel_b;
  logic [8:0]  ch_addr_a, ch_addr_b;
  logic        ch_re_a, ch_re_b, ch_we_a, ch_we_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  xpar_bridge #(
    .DATA_W(32), .ADDR_W(12), .N_CH(4), .WAIT_CYC(1), .USE_ACK(1'b0), .TIMEOUT(64)
  ) dut_a (
    .clk(clk), .rst(rst), .sel(sel_a), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out_a), .stall(stall_a), .err(err_a), .err_ch(err_ch_a),
    .ch_sel(ch_sel_a), .ch_addr(ch_addr_a), .ch_out(ch_out_a), .ch_re(ch_re_a),
    .ch_we(ch_we_a), .ch_in(ch_in), .ch_ack(ack_a)
  );

  xpar_bridge #(
    .DATA_W(32), .ADDR_W(12), .N_CH(4), .WAIT_CYC(3), .USE_ACK(1'b1), .TIMEOUT(64)
  ) dut_b (
    .clk(clk), .rst(rst), .sel(sel_b), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out_b), .stall(stall_b), .err(err_b), .err_ch(err_ch_b),
    .ch_sel(ch_sel_b), .ch_addr(ch_addr_b), .ch_out(ch_out_b), .ch_re(ch_re_b),
    .ch_we(ch_we_b), .ch_in(ch_in), .ch_ack(ack_b)
  );

  // Runs one access as a controller would: hold sel while stalled, drop it in DONE.
  // ack_at raises the addressed channel's ack during that strobe cycle (0 = never).
  task automatic do_access(input bit b, input logic [1:0] ch, input logic [8:0] la,
                           input logic w, input logic [31:0] wd, input int ack_at,
                           input logic [3:0] ack_bg, output int strobe_n,
                           output int stall_n, output int re_n, output int we_n,
                           output logic [3:0] sel_seen, output logic [8:0] addr_seen,
                           output logic [31:0] out_seen, output bit hold_bad,
                           output logic [31:0] dout, output bit hung);
    logic        st, cre, cwe;
    logic [3:0]  cs;
    logic [8:0]  ca;
    logic [31:0] co;
    strobe_n = 0; stall_n = 0; re_n = 0; we_n = 0;
    sel_seen = '0; addr_seen = '0; out_seen = '0; hold_bad = 0; dout = '0; hung = 1;
    @(negedge clk);
    addr = {ch, la}; we = w; data_in = wd;
    if (b) begin sel_b = 1'b1; ack_b = ack_bg; end
    else begin sel_a = 1'b1; ack_a = ack_bg; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      #1;
      st  = b ? stall_b : stall_a;
      cs  = b ? ch_sel_b : ch_sel_a;
      ca  = b ? ch_addr_b : ch_addr_a;
      co  = b ? ch_out_b : ch_out_a;
      cre = b ? ch_re_b : ch_re_a;
      cwe = b ? ch_we_b : ch_we_a;
      if (!st) begin
        dout = b ? data_out_b : data_out_a;
        hung = 0;
        break;
      end
      stall_n++;
      if (cs != 4'b0) begin
        strobe_n++;
        if (strobe_n == 1) begin
          sel_seen = cs; addr_seen = ca; out_seen = co;
        end else if (cs !== sel_seen || ca !== addr_seen || co !== out_seen) begin
          hold_bad = 1;
        end
        re_n += int'(cre);
        we_n += int'(cwe);
        if (strobe_n == ack_at) begin
          if (b) ack_b[ch] = 1'b1;
          else ack_a[ch] = 1'b1;
        end
      end
      @(negedge clk);
    end
    sel_a = 1'b0; sel_b = 1'b0; ack_a = '0; ack_b = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if ({data_out_a, stall_a, err_a, err_ch_a, ch_sel_a, ch_addr_a, ch_out_a, ch_re_a,
         ch_we_a} !== '0) begin
      miscompares++; $display("FAIL reset_a: outputs not all zero");
    end
    vectors++;
    if ({data_out_b, stall_b, err_b, err_ch_b, ch_sel_b, ch_addr_b, ch_out_b, ch_re_b,
         ch_we_b} !== '0) begin
      miscompares++; $display("FAIL reset_b: outputs not all zero");
    end
    rst = 1'b0;
  endtask

  task automatic test_fixed_write();
    int sn, stn, rn, wn; logic [3:0] ss; logic [8:0] as; logic [31:0] os, d; bit hb, h;
    do_access(1'b0, 2'd2, 9'h005, 1'b1, 32'hA5A5A5A5, 0, 4'b0, sn, stn, rn, wn, ss, as,
              os, hb, d, h);
    vectors++; if (h !== 0) begin miscompares++; $display("FAIL wr_hung: got %0d want 0", h); end
    vectors++; if (sn != 1) begin miscompares++; $display("FAIL wr_strobe_len: got %0d want 1", sn); end
    vectors++; if (wn != 1 || rn != 0) begin
      miscompares++; $display("FAIL wr_we_re: got we %0d re %0d want 1 0", wn, rn); end
    vectors++; if (ss !== 4'b0100) begin miscompares++; $display("FAIL wr_ch_sel: got %b want 0100", ss); end
    vectors++; if (as !== 9'h005) begin miscompares++; $display("FAIL wr_ch_addr: got %h want 005", as); end
    vectors++; if (os !== 32'hA5A5A5A5) begin
      miscompares++; $display("FAIL wr_ch_out: got %h want a5a5a5a5", os); end
    vectors++; if (stn != 2) begin miscompares++; $display("FAIL wr_stall_len: got %0d want 2", stn); end
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL wr_data_out: got %h want 0", d); end
  endtask

  task automatic test_fixed_read();
    int sn, stn, rn, wn; logic [3:0] ss; logic [8:0] as; logic [31:0] os, d; bit hb, h;
    // No ack ever: with USE_ACK=0 timing is fixed anyway.
    do_access(1'b0, 2'd3, 9'h1F0, 1'b0, 32'h0, 0, 4'b0, sn, stn, rn, wn, ss, as, os, hb, d, h);
    vectors++; if (sn != 1 || rn != 1) begin
      miscompares++; $display("FAIL fr_strobe: got len %0d re %0d want 1 1", sn, rn); end
    vectors++; if (d !== 32'h0BADBEEF) begin
      miscompares++; $display("FAIL fr_data_out: got %h want 0badbeef", d); end
    vectors++; if (ss !== 4'b1000 || as !== 9'h1F0) begin
      miscompares++; $display("FAIL fr_sel_addr: got %b %h want 1000 1f0", ss, as); end
  endtask

  task automatic test_ack_read();
    int sn, stn, rn, wn; logic [3:0] ss; logic [8:0] as; logic [31:0] os, d; bit hb, h;
    do_access(1'b1, 2'd1, 9'h033, 1'b0, 32'h0, 5, 4'b0, sn, stn, rn, wn, ss, as, os, hb, d, h);
    vectors++; if (sn != 5) begin miscompares++; $display("FAIL ack_strobe_len: got %0d want 5", sn); end
    vectors++; if (stn != 6) begin miscompares++; $display("FAIL ack_stall_len: got %0d want 6", stn); end
    vectors++; if (d !== 32'h12345678) begin
      miscompares++; $display("FAIL ack_data_out: got %h want 12345678", d); end
    vectors++; if (err_b !== 1'b0) begin miscompares++; $display("FAIL ack_err: got %b want 0", err_b); end
    vectors++; if (ss !== 4'b0010 || hb) begin
      miscompares++; $display("FAIL ack_sel_hold: got %b hold_bad %0d want 0010 0", ss, hb); end
  endtask

  task automatic test_ack_at_timeout();
    int sn, stn, rn, wn; logic [3:0] ss; logic [8:0] as; logic [31:0] os, d; bit hb, h;
    do_access(1'b1, 2'd2, 9'h044, 1'b0, 32'h0, 64, 4'b0, sn, stn, rn, wn, ss, as, os, hb, d, h);
    vectors++; if (sn != 64) begin miscompares++; $display("FAIL edge_strobe_len: got %0d want 64", sn); end
    vectors++; if (d !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL edge_data_out: got %h want cafef00d", d); end
    vectors++; if (err_b !== 1'b0) begin miscompares++; $display("FAIL edge_err: got %b want 0", err_b); end
  endtask

  task automatic test_timeout();
    int sn, stn, rn, wn; logic [3:0] ss; logic [8:0] as; logic [31:0] os, d; bit hb, h;
    do_access(1'b1, 2'd0, 9'h0AA, 1'b0, 32'h0, 0, 4'b0, sn, stn, rn, wn, ss, as, os, hb, d, h);
    vectors++; if (sn != 64) begin miscompares++; $display("FAIL to_strobe_len: got %0d want 64", sn); end
    vectors++; if (err_b !== 1'b1 || err_ch_b !== 2'd0) begin
      miscompares++; $display("FAIL to_err: got %b ch %0d want 1 0", err_b, err_ch_b); end
    vectors++; if (d !== 32'hFFFFFFFF) begin
      miscompares++; $display("FAIL to_data_out: got %h want ffffffff", d); end
    // A following normal access still completes; err stays sticky.
    do_access(1'b1, 2'd3, 9'h001, 1'b0, 32'h0, 3, 4'b0, sn, stn, rn, wn, ss, as, os, hb, d, h);
    vectors++; if (sn != 3 || d !== 32'h0BADBEEF) begin
      miscompares++; $display("FAIL to_follow: got len %0d data %h want 3 0badbeef", sn, d); end
    vectors++; if (err_b !== 1'b1 || err_ch_b !== 2'd0) begin
      miscompares++; $display("FAIL to_sticky: got %b ch %0d want 1 0", err_b, err_ch_b); end
  endtask

  task automatic test_foreign_ack();
    int sn, stn, rn, wn; logic [3:0] ss; logic [8:0] as; logic [31:0] os, d; bit hb, h;
    do_access(1'b1, 2'd3, 9'h100, 1'b1, 32'h00C0FFEE, 0, 4'b0010, sn, stn, rn, wn, ss, as,
              os, hb, d, h);
    vectors++; if (sn != 64 || wn != 64) begin
      miscompares++; $display("FAIL fa_strobe_len: got %0d we %0d want 64 64", sn, wn); end
    vectors++; if (err_b !== 1'b1 || err_ch_b !== 2'd3) begin
      miscompares++; $display("FAIL fa_err_ch: got %b ch %0d want 1 3", err_b, err_ch_b); end
    vectors++; if (d !== 32'h0BADBEEF) begin
      miscompares++; $display("FAIL fa_data_out: got %h want 0badbeef", d); end
    vectors++; if (hb || os !== 32'h00C0FFEE) begin
      miscompares++; $display("FAIL fa_hold: got out %h hold_bad %0d want 00c0ffee 0", os, hb); end
  endtask

  task automatic test_reset_mid_access();
    int sn, stn, rn, wn; logic [3:0] ss; logic [8:0] as; logic [31:0] os, d; bit hb, h;
    @(negedge clk);
    addr = {2'd0, 9'h011}; we = 1'b0; sel_b = 1'b1; ack_b = 4'b0;
    repeat (4) @(negedge clk);
    #1;
    vectors++; if (ch_sel_b !== 4'b0001 || ch_re_b !== 1'b1) begin
      miscompares++; $display("FAIL mr_active: got %b re %b want 0001 1", ch_sel_b, ch_re_b); end
    rst = 1'b1; sel_b = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({ch_sel_b, ch_re_b, ch_we_b, stall_b, err_b, data_out_b} !== '0) begin
      miscompares++;
      $display("FAIL mr_outputs: got sel %b re %b we %b stall %b err %b data %h want all 0",
               ch_sel_b, ch_re_b, ch_we_b, stall_b, err_b, data_out_b);
    end
    @(negedge clk); rst = 1'b0;
    do_access(1'b1, 2'd1, 9'h002, 1'b0, 32'h0, 3, 4'b0, sn, stn, rn, wn, ss, as, os, hb, d, h);
    vectors++; if (sn != 3 || stn != 4 || d !== 32'h12345678) begin
      miscompares++;
      $display("FAIL mr_after: got len %0d stall %0d data %h want 3 4 12345678", sn, stn, d);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; data_in = '0;
    sel_a = 1'b0; sel_b = 1'b0; ack_a = '0; ack_b = '0;
    ch_in = {32'h0BADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h5A5A0F0F};
    test_reset();
    test_fixed_write();
    test_fixed_read();
    test_ack_read();
    test_ack_at_timeout();
    test_timeout();
    test_foreign_ack();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xpar_bridge.md
Name: xpar_bridge

Overview:
Parametrised successor to the single external parallel port. It bridges the controller data bus to N_CH external parallel channels. Each transaction is latched and issued to exactly one channel. The bridge inserts programmable wait states, supports an optional per-channel ready/ack handshake, and stalls the controller until the transaction completes. A timeout guard terminates hung accesses and reports them through sticky error status.

Parameters:
DATA_W, 32, data bus width
ADDR_W, 12, controller address width; bridge sees ADDR_W-1 bits
N_CH, 4, number of external channels (power of 2, 1..16)
CH_W, $clog2(N_CH) (min 1), channel index width
WAIT_CYC, 1, minimum strobe cycles per access (1..15)
USE_ACK, 1, 1 = completion also requires ch_ack; 0 = fixed WAIT_CYC timing
TIMEOUT, 64, max strobe cycles before forced abort (> WAIT_CYC)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sel  in  1  bridge selected by address decoder
we  in  1  1 = write, 0 = read
addr  in  ADDR_W-1  bus address; top CH_W bits = channel, rest = local address
data_in  in  DATA_W  write data
data_out  out  DATA_W  read data, held after completion
stall  out  1  controller must hold bus while high
err  out  1  sticky timeout flag
err_ch  out  CH_W  channel of the most recent timeout
ch_sel  out  N_CH  one-hot channel strobe
ch_addr  out  ADDR_W-1-CH_W  local address
ch_out  out  DATA_W  write data to channels
ch_re  out  1  read strobe (ch_sel & ~we)
ch_we  out  1  write strobe (ch_sel & we)
ch_in  in  N_CH*DATA_W  read data; channel k occupies bits [k*DATA_W +: DATA_W]
ch_ack  in  N_CH  per-channel ready

Behaviour:
- Single clock domain. Reset is synchronous and active-high; when rst is high on a rising clk edge, every output goes to 0 and the state goes to IDLE.
- FSM states:
  - IDLE: sel=1 → latch addr/we/data_in, go ACCESS, cnt=1.
  - ACCESS: issue the access and count strobe cycles (exit conditions below).
  - DONE: one cycle; stall=0; return to IDLE.
- stall behaviour:
  - Combinational: stall = (IDLE & sel) | ACCESS.
  - The controller sees stall in the same cycle it presents sel.
- Strobe outputs:
  - ch_sel, ch_re, ch_we, ch_addr and ch_out are registered from the latched values.
  - They are asserted only in ACCESS and are 0 otherwise.
  - ch_addr and ch_out hold their values throughout ACCESS.
- ACCESS exit conditions, evaluated each cycle; cnt increments each cycle:
  - Complete when cnt >= WAIT_CYC and (USE_ACK=0 or ch_ack[ch]=1). On a read, capture ch_in[ch] into data_out, then go DONE.
  - Timeout when cnt == TIMEOUT and not complete: set err=1, err_ch=ch, data_out={DATA_W{1'b1}} on a read, go DONE.
  - If complete and timeout happen in the same cycle, completion wins.
- Bus behaviour:
  - Writes leave data_out unchanged.
  - ch_ack on a non-selected channel is ignored.
  - sel while in ACCESS/DONE is ignored. The controller holds sel under stall, so the next access is accepted in the following IDLE.
  - Back-to-back accesses therefore take WAIT_CYC+2 cycles each at minimum.
- Error status: err and err_ch clear only on rst.
- Latency: read data is valid on data_out in the DONE cycle and stays valid until the next read completes.
- cnt saturates at TIMEOUT; its width is $clog2(TIMEOUT+1).
- Reset during ACCESS: strobes drop on the next edge and no data is captured.

Decomposition:
- Shared include xdefs.vh gains:
  - `XPAR_N_CH, `XPAR_WAIT, `XPAR_TIMEOUT defaults
  - state encodings IDLE=2'd0, ACCESS=2'd1, DONE=2'd2
- One sub-module, xpar_rdmux: combinational N_CH:1 read-data mux indexed by the latched channel. It is reused by the address decoder for its own read mux.
- xtop instantiates xpar_bridge in place of the direct par_* assignments.

Test Plan:
1. WAIT_CYC=1, USE_ACK=0: write ch2 addr local 0x05 data 0xA5A5A5A5.
   - ch_sel=4'b0100 and ch_we=1 for exactly 1 cycle; ch_out=0xA5A5A5A5.
   - stall high for 2 cycles; data_out unchanged.
2. WAIT_CYC=3, USE_ACK=1, ch1 ack raised at strobe cycle 5: read with ch_in[1]=0x12345678.
   - Strobe lasts 5 cycles; data_out=0x12345678 in DONE; err=0.
3. ch0 ack never asserted, TIMEOUT=64: read.
   - Strobe lasts 64 cycles; err=1, err_ch=0, data_out=0xFFFFFFFF.
   - A following ch3 access completes normally and err stays 1.
4. ch_ack[1]=1 held high while accessing ch3 with USE_ACK=1 (ch3 ack low).
   - No early completion; timeout on ch3, err_ch=3.
5. Ack arriving exactly on strobe cycle TIMEOUT → completes with valid data and err stays 0. rst asserted in the middle of ACCESS → all strobes and stall 0 on the next edge, FSM in IDLE.
